// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one uart_tx among N_REQ byte streams.
// Optional grant-stall timeout enabled by defining UART_ARB_TIMEOUT_EN (adds err_timeout port).
module uart_tx_arbiter #(
   parameter int N_REQ     = 2,
   parameter int BUSY_WAIT = 4,
   parameter int TIMEOUT   = 100000
) (
   input  logic                                           clk,
   input  logic                                           rst,
   input  logic [N_REQ-1:0]                               req_valid,
   input  logic [8*N_REQ-1:0]                             req_data,
   input  logic [N_REQ-1:0]                               req_last,
   output logic [N_REQ-1:0]                               req_ready,
   output logic                                           tx_start,
   output logic [7:0]                                     tx_data,
   input  logic                                           tx_busy,
   output logic                                           grant_active,
   output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0]   grant_owner,
   output logic                                           err_no_busy
`ifdef UART_ARB_TIMEOUT_EN
   ,
   output logic                                           err_timeout
`endif
);

   localparam int          OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int          WW = $clog2(BUSY_WAIT + 1);
   localparam int unsigned NR = N_REQ;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      START,
      WAIT_HI,
      WAIT_LO
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   rr_q, rr_d;
   logic [OW-1:0]   rr_next;
   logic [OW-1:0]   winner;
   logic            found;
   logic            active_q, active_d;
   logic            last_q, last_d;
   logic            err_nb_q, err_nb_d;
   logic [7:0]      data_q, data_d;
   logic [WW-1:0]   wait_q, wait_d;
   int unsigned     scan_idx;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0]   to_q, to_d;
   logic            err_to_q, err_to_d;
`endif

   // First valid requester at or after the rr pointer, wrapping modulo N_REQ.
   always_comb begin
      found    = 1'b0;
      winner   = '0;
      scan_idx = 0;
      for (int unsigned i = 0; i < NR; i++) begin
         scan_idx = i + 32'(rr_q);
         if (scan_idx >= NR) scan_idx = scan_idx - NR;
         if (!found && req_valid[OW'(scan_idx)]) begin
            found  = 1'b1;
            winner = OW'(scan_idx);
         end
      end
   end

   assign rr_next = (owner_q == OW'(NR - 1)) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      rr_d      = rr_q;
      active_d  = active_q;
      last_d    = last_q;
      err_nb_d  = err_nb_q;
      data_d    = data_q;
      wait_d    = wait_q;
      req_ready = '0;
      tx_start  = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_d      = to_q;
      err_to_d  = err_to_q;
`endif

      case (state_q)
         IDLE: begin
            if (found) begin
               owner_d  = winner;
               active_d = 1'b1;
               state_d  = GRANT;
`ifdef UART_ARB_TIMEOUT_EN
               to_d     = '0;
`endif
            end
         end

         GRANT: begin
            // Never hand uart_tx a new byte while it is still shifting the previous one.
            if (!tx_busy) begin
               req_ready[owner_q] = 1'b1;
               if (req_valid[owner_q]) begin
                  data_d  = req_data[{owner_q, 3'b000} +: 8];
                  last_d  = req_last[owner_q];
                  state_d = START;
               end
            end
`ifdef UART_ARB_TIMEOUT_EN
            if (!tx_busy && req_valid[owner_q]) begin
               to_d = '0;
            end else if (!req_valid[owner_q]) begin
               if (to_q == TW'(TIMEOUT - 1)) begin
                  to_d     = '0;
                  err_to_d = 1'b1;
                  active_d = 1'b0;
                  rr_d     = rr_next;
                  state_d  = IDLE;
               end else begin
                  to_d = to_q + 1'b1;
               end
            end
`endif
         end

         START: begin
            tx_start = 1'b1;
            wait_d   = '0;
            state_d  = WAIT_HI;
         end

         WAIT_HI: begin
            if (tx_busy) begin
               state_d = WAIT_LO;
            end else if (wait_q == WW'(BUSY_WAIT - 1)) begin
               // uart_tx never acknowledged: flag it and treat the byte as sent.
               err_nb_d = 1'b1;
               state_d  = WAIT_LO;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         WAIT_LO: begin
            if (!tx_busy) begin
               if (last_q) begin
                  active_d = 1'b0;
                  rr_d     = rr_next;
                  state_d  = IDLE;
               end else begin
                  state_d = GRANT;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_q     <= '0;
         active_q <= 1'b0;
         last_q   <= 1'b0;
         err_nb_q <= 1'b0;
         data_q   <= '0;
         wait_q   <= '0;
`ifdef UART_ARB_TIMEOUT_EN
         to_q     <= '0;
         err_to_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         active_q <= active_d;
         last_q   <= last_d;
         err_nb_q <= err_nb_d;
         data_q   <= data_d;
         wait_q   <= wait_d;
`ifdef UART_ARB_TIMEOUT_EN
         to_q     <= to_d;
         err_to_q <= err_to_d;
`endif
      end
   end

   assign tx_data      = data_q;
   assign grant_active = active_q;
   assign grant_owner  = owner_q;
   assign err_no_busy  = err_nb_q;
`ifdef UART_ARB_TIMEOUT_EN
   assign err_timeout  = err_to_q;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter (N_REQ=2): queued requesters, uart_tx busy model, byte scoreboard.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int TB_TIMEOUT = 20;
`else
   localparam int TB_TIMEOUT = 100000;
`endif

   typedef struct {
      logic [7:0] d;
      logic       last;
   } byte_t;

   typedef struct {
      logic [7:0] d;
      logic       own;
   } exp_t;

   typedef struct {
      logic [1:0]  mask;
      logic [7:0]  b0;
      logic [7:0]  b1;
      int unsigned len;
      logic        first;
      logic        end_own;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid;
   logic [15:0] req_data;
   logic [1:0]  req_last;
   logic [1:0]  req_ready;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy = 1'b0;
   logic        grant_active;
   logic [0:0]  grant_owner;
   logic        err_no_busy;
`ifdef UART_ARB_TIMEOUT_EN
   logic        err_timeout;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned start_cnt = 0;
   logic        acc0 = 1'b0, acc1 = 1'b0, acc_prev = 1'b0;
   logic        hold_valid = 1'b0;
   logic [7:0]  hold_d = '0;
   logic        no_busy = 1'b0;
   int unsigned busy_len = 10;
   int unsigned bcnt = 0;

   byte_t src_q0[$];
   byte_t src_q1[$];
   exp_t  sb_q[$];

   uart_tx_arbiter #(
      .N_REQ(2),
      .BUSY_WAIT(4),
      .TIMEOUT(TB_TIMEOUT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .req_valid(req_valid),
      .req_data(req_data),
      .req_last(req_last),
      .req_ready(req_ready),
      .tx_start(tx_start),
      .tx_data(tx_data),
      .tx_busy(tx_busy),
      .grant_active(grant_active),
      .grant_owner(grant_owner),
      .err_no_busy(err_no_busy)
`ifdef UART_ARB_TIMEOUT_EN
      ,
      .err_timeout(err_timeout)
`endif
   );

   always #5 clk = ~clk;

   // uart_tx model: busy for busy_len cycles after a sampled start, or never when no_busy.
   always @(posedge clk) begin
      if (tx_start && !no_busy) begin
         tx_busy <= 1'b1;
         bcnt    <= busy_len;
      end else if (bcnt > 1) begin
         bcnt <= bcnt - 1;
      end else begin
         tx_busy <= 1'b0;
         bcnt    <= 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic enq_byte(input int r, input logic [7:0] d, input logic l);
      byte_t b;
      b.d    = d;
      b.last = l;
      if (r == 0) src_q0.push_back(b);
      else        src_q1.push_back(b);
   endtask

   task automatic enq(input int r, input logic [7:0] base, input int unsigned len);
      for (int unsigned k = 0; k < len; k++) enq_byte(r, base + 8'(k), (k == len - 1));
   endtask

   task automatic exp_byte(input int r, input logic [7:0] d);
      exp_t e;
      e.d   = d;
      e.own = (r != 0);
      sb_q.push_back(e);
   endtask

   task automatic exp_msg(input int r, input logic [7:0] base, input int unsigned len);
      for (int unsigned k = 0; k < len; k++) exp_byte(r, base + 8'(k));
   endtask

   task automatic present();
      req_valid[0]   = (src_q0.size() != 0);
      req_data[7:0]  = (src_q0.size() != 0) ? src_q0[0].d : 8'h00;
      req_last[0]    = (src_q0.size() != 0) ? src_q0[0].last : 1'b0;
      req_valid[1]   = (src_q1.size() != 0);
      req_data[15:8] = (src_q1.size() != 0) ? src_q1[0].d : 8'h00;
      req_last[1]    = (src_q1.size() != 0) ? src_q1[0].last : 1'b0;
   endtask

   // Requester driver plus output monitor; acceptance is judged just before the edge that takes it.
   initial begin
      exp_t e;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            chk("start_lat", 32'(tx_start), 32'(acc_prev));
            if (tx_start) begin
               start_cnt++;
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_extra got=%0h want=none", tx_data);
               end else begin
                  e = sb_q.pop_front();
                  chk("tx_data", 32'(tx_data), 32'(e.d));
                  chk("tx_owner", 32'(grant_owner), 32'(e.own));
               end
               hold_valid = 1'b1;
               hold_d     = tx_data;
            end
            if (tx_busy) begin
               if (hold_valid) chk("hold_data", 32'(tx_data), 32'(hold_d));
               chk("busy_ready", 32'(req_ready), 32'd0);
            end
            acc0 = req_valid[0] & req_ready[0];
            acc1 = req_valid[1] & req_ready[1];
         end else begin
            acc0       = 1'b0;
            acc1       = 1'b0;
            hold_valid = 1'b0;
         end
         acc_prev = acc0 | acc1;
         @(posedge clk);
         #1;
         if (acc0 && src_q0.size() != 0) void'(src_q0.pop_front());
         if (acc1 && src_q1.size() != 0) void'(src_q1.pop_front());
         present();
      end
   end

   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic drain(input string nm);
      int unsigned n = 0;
      while (!(sb_q.size() == 0 && src_q0.size() == 0 && src_q1.size() == 0 &&
               !grant_active && !tx_busy) && n < 3000) begin
         tick();
         n++;
      end
      chk({nm, "_drain"}, 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_starts(input int unsigned tgt, input string nm);
      int unsigned n = 0;
      while (start_cnt < tgt && n < 500) begin
         tick();
         n++;
      end
      chk({nm, "_start_wait"}, 32'(start_cnt >= tgt), 32'd1);
   endtask

   task automatic wait_busy(input logic lvl, input string nm);
      int unsigned n = 0;
      while (tx_busy !== lvl && n < 500) begin
         tick();
         n++;
      end
      chk({nm, "_busy_wait"}, 32'(tx_busy === lvl), 32'd1);
   endtask

   task automatic check_reset_vals(input string nm);
      chk({nm, "_ready"},  32'(req_ready),    32'd0);
      chk({nm, "_start"},  32'(tx_start),     32'd0);
      chk({nm, "_data"},   32'(tx_data),      32'd0);
      chk({nm, "_active"}, 32'(grant_active), 32'd0);
      chk({nm, "_owner"},  32'(grant_owner),  32'd0);
      chk({nm, "_errnb"},  32'(err_no_busy),  32'd0);
`ifdef UART_ARB_TIMEOUT_EN
      chk({nm, "_errto"},  32'(err_timeout),  32'd0);
`endif
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl [6];
      int unsigned s;

      // Each row starts from the rr pointer left behind by the previous row (0 after reset).
      tbl[0] = '{mask: 2'b11, b0: 8'h10, b1: 8'h20, len: 3, first: 1'b0, end_own: 1'b1};
      tbl[1] = '{mask: 2'b10, b0: 8'h00, b1: 8'h30, len: 1, first: 1'b1, end_own: 1'b1};
      tbl[2] = '{mask: 2'b01, b0: 8'h40, b1: 8'h00, len: 2, first: 1'b0, end_own: 1'b0};
      tbl[3] = '{mask: 2'b11, b0: 8'h50, b1: 8'h60, len: 1, first: 1'b1, end_own: 1'b0};
      tbl[4] = '{mask: 2'b10, b0: 8'h00, b1: 8'h70, len: 2, first: 1'b1, end_own: 1'b1};
      tbl[5] = '{mask: 2'b11, b0: 8'h88, b1: 8'h98, len: 2, first: 1'b0, end_own: 1'b1};

      rst = 1'b1;
      repeat (3) @(posedge clk);
      tick();
      check_reset_vals("por");
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) begin
         if (tbl[i].mask[0]) enq(0, tbl[i].b0, tbl[i].len);
         if (tbl[i].mask[1]) enq(1, tbl[i].b1, tbl[i].len);
         if (tbl[i].mask == 2'b11) begin
            if (tbl[i].first == 1'b0) begin
               exp_msg(0, tbl[i].b0, tbl[i].len);
               exp_msg(1, tbl[i].b1, tbl[i].len);
            end else begin
               exp_msg(1, tbl[i].b1, tbl[i].len);
               exp_msg(0, tbl[i].b0, tbl[i].len);
            end
         end else if (tbl[i].mask[0]) begin
            exp_msg(0, tbl[i].b0, tbl[i].len);
         end else begin
            exp_msg(1, tbl[i].b1, tbl[i].len);
         end
         drain("vec");
         chk("vec_owner",  32'(grant_owner),  32'(tbl[i].end_own));
         chk("vec_active", 32'(grant_active), 32'd0);
      end

      // Fairness: req0 has two messages queued back to back, req1 one; rr is 0 here.
      enq(0, 8'hA0, 2);
      enq(0, 8'hA8, 2);
      enq(1, 8'hB0, 2);
      exp_msg(0, 8'hA0, 2);
      exp_msg(1, 8'hB0, 2);
      exp_msg(0, 8'hA8, 2);
      drain("fair");
      chk("fair_owner", 32'(grant_owner), 32'd0);

      // "Hi" from req0; grant_active must drop exactly one cycle after the second busy fall.
      s = start_cnt;
      enq_byte(0, 8'h48, 1'b0);
      enq_byte(0, 8'h69, 1'b1);
      exp_byte(0, 8'h48);
      exp_byte(0, 8'h69);
      wait_starts(s + 2, "hi");
      wait_busy(1'b1, "hi_up");
      wait_busy(1'b0, "hi_dn");
      chk("hi_active_hold", 32'(grant_active), 32'd1);
      tick();
      chk("hi_active_fall", 32'(grant_active), 32'd0);
      chk("hi_owner", 32'(grant_owner), 32'd0);
      drain("hi");
      chk("hi_starts", 32'(start_cnt - s), 32'd2);

      // Reset in WAIT_LO of byte 2 of 4; rr is 1 beforehand so a req0-first grant proves rr=0.
      s = start_cnt;
      enq(0, 8'hC0, 4);
      exp_msg(0, 8'hC0, 2);
      wait_starts(s + 2, "mid");
      wait_busy(1'b1, "mid_up");
      tick();
      tick();
      rst = 1'b1;
      src_q0.delete();
      tick();
      check_reset_vals("mid");
      rst = 1'b0;
      enq(0, 8'hD0, 1);
      enq(1, 8'hE0, 1);
      exp_msg(0, 8'hD0, 1);
      exp_msg(1, 8'hE0, 1);
      drain("mid");
      chk("mid_owner", 32'(grant_owner), 32'd1);

      // uart_tx never asserts busy: err_no_busy rises after exactly BUSY_WAIT WAIT_HI cycles.
      no_busy = 1'b1;
      s = start_cnt;
      enq(0, 8'hF0, 2);
      exp_msg(0, 8'hF0, 2);
      wait_starts(s + 1, "nb");
      repeat (4) tick();
      chk("nb_err_early", 32'(err_no_busy), 32'd0);
      tick();
      chk("nb_err_set", 32'(err_no_busy), 32'd1);
      drain("nb");
      chk("nb_err_sticky", 32'(err_no_busy), 32'd1);
      chk("nb_starts", 32'(start_cnt - s), 32'd2);
      no_busy = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
      s = start_cnt;
      enq_byte(0, 8'hA5, 1'b0);
      exp_byte(0, 8'hA5);
      wait_starts(s + 1, "to");
      enq(1, 8'hB5, 1);
      exp_msg(1, 8'hB5, 1);
      drain("to");
      chk("to_err", 32'(err_timeout), 32'd1);
      chk("to_owner", 32'(grant_owner), 32'd1);
`endif

      rst = 1'b1;
      tick();
      check_reset_vals("end");
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
